// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit core sequencer.
package cpu_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned NIB_W  = 4;

  localparam logic [7:0] OP_HALT = 8'hDF;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    STEP = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    HC_NONE  = 2'd0,
    HC_INSTR = 2'd1,
    HC_REQ   = 2'd2,
    HC_BP    = 2'd3
  } halt_cause_t;

endpackage

// File: rtl/pc_next.sv
// Next fetch address: reset, jump resolve, or sequential increment.
module pc_next
  import cpu_pkg::*;
(
  input  logic              sync_reset,
  input  logic              jmp,
  input  logic              jmp_nz,
  input  logic [NIB_W-1:0]  ir_nibble,
  input  logic              dont_jmp,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] nxt
);

  // Priority: reset, unconditional jump, taken conditional jump, increment.
  always_comb begin
    nxt = pc + ADDR_W'(1);
    if (sync_reset) begin
      nxt = '0;
    end else if (jmp || (jmp_nz && !dont_jmp)) begin
      nxt = {ir_nibble, NIB_W'(0)};
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Program counter, fetch address and RUN/HALT/STEP debug control.
module program_sequencer
  import cpu_pkg::*;
#(
  parameter bit RESET_HALTED = 1'b0
) (
  input  logic              clk,
  input  logic              sync_reset,
  input  logic              jmp,
  input  logic              jmp_nz,
  input  logic [NIB_W-1:0]  ir_nibble,
  input  logic              dont_jmp,
  input  logic              NOPDF,
  input  logic              dbg_halt_req,
  input  logic              dbg_resume,
  input  logic              dbg_step,
  input  logic              dbg_bp_en,
  input  logic [ADDR_W-1:0] dbg_bp_addr,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] from_PS,
  output logic              stall,
  output logic              halted,
  output logic [1:0]        halt_cause
);

  localparam seq_state_t RST_STATE = RESET_HALTED ? HALT : RUN;

  seq_state_t        state;
  seq_state_t        state_nxt;
  halt_cause_t       hc_nxt;
  logic [ADDR_W-1:0] nxt;
  logic              bp_hit;

  pc_next u_pc_next (
    .sync_reset (sync_reset),
    .jmp        (jmp),
    .jmp_nz     (jmp_nz),
    .ir_nibble  (ir_nibble),
    .dont_jmp   (dont_jmp),
    .pc         (pc),
    .nxt        (nxt)
  );

  assign from_PS = pc;
  assign bp_hit  = dbg_bp_en && (nxt == dbg_bp_addr);

  // Fetch address: hold the current pc while halted, otherwise fetch ahead.
  always_comb begin
    pm_addr = nxt;
    if ((state == HALT) && !sync_reset) begin
      pm_addr = pc;
    end
  end

  // State, pc and debug status registers.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state      <= RST_STATE;
      pc         <= '0;
      halt_cause <= HC_NONE;
      stall      <= RESET_HALTED;
      halted     <= RESET_HALTED;
    end else begin
      state      <= state_nxt;
      pc         <= pm_addr;
      halt_cause <= hc_nxt;
      stall      <= (state_nxt == HALT);
      halted     <= (state_nxt == HALT);
    end
  end

  // Debug transitions; the breakpoint looks only at the address about to be fetched.
  always_comb begin
    state_nxt = state;
    hc_nxt    = halt_cause_t'(halt_cause);
    case (state)
      RUN: begin
        if (NOPDF) begin
          state_nxt = HALT;
          hc_nxt    = HC_INSTR;
        end else if (dbg_halt_req) begin
          state_nxt = HALT;
          hc_nxt    = HC_REQ;
        end else if (bp_hit) begin
          state_nxt = HALT;
          hc_nxt    = HC_BP;
        end
      end
      HALT: begin
        if (dbg_resume) begin
          state_nxt = RUN;
          hc_nxt    = HC_NONE;
        end else if (dbg_step) begin
          state_nxt = STEP;
          hc_nxt    = HC_NONE;
        end
      end
      STEP: begin
        state_nxt = HALT;
        hc_nxt    = NOPDF ? HC_INSTR : HC_NONE;
      end
      default: begin
        state_nxt = RUN;
        hc_nxt    = HC_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed vector table plus randomized run against a reference model.
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       rst, jmp, jnz, dz, nop, req, res, stp, bpen;
  logic [3:0] nib;
  logic [7:0] bpa;

  logic [7:0] pm0, pc0, fps0, pm1, pc1, fps1;
  logic       st0, hl0, st1, hl1;
  logic [1:0] hc0, hc1;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  program_sequencer #(.RESET_HALTED(1'b0)) dut (
    .clk(clk), .sync_reset(rst), .jmp(jmp), .jmp_nz(jnz), .ir_nibble(nib),
    .dont_jmp(dz), .NOPDF(nop), .dbg_halt_req(req), .dbg_resume(res),
    .dbg_step(stp), .dbg_bp_en(bpen), .dbg_bp_addr(bpa),
    .pm_addr(pm0), .pc(pc0), .from_PS(fps0), .stall(st0), .halted(hl0),
    .halt_cause(hc0)
  );

  program_sequencer #(.RESET_HALTED(1'b1)) dut_h (
    .clk(clk), .sync_reset(rst), .jmp(jmp), .jmp_nz(jnz), .ir_nibble(nib),
    .dont_jmp(dz), .NOPDF(nop), .dbg_halt_req(req), .dbg_resume(res),
    .dbg_step(stp), .dbg_bp_en(bpen), .dbg_bp_addr(bpa),
    .pm_addr(pm1), .pc(pc1), .from_PS(fps1), .stall(st1), .halted(hl1),
    .halt_cause(hc1)
  );

  typedef struct {
    logic       rst, jmp, jnz, dz, nop, req, res, stp, bpen;
    logic [3:0] nib;
    logic [7:0] bpa;
    logic [7:0] e_pm, e_pc;
    logic       e_halt;
    logic [1:0] e_hc;
  } vec_t;

  // mode: 0 running, 1 halted, 2 single-stepping
  typedef struct {
    logic [7:0] pc;
    int         mode;
    logic [1:0] cause;
  } mdl_t;

  vec_t tbl[$];
  mdl_t m0, m1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t row(input logic [7:0] pc_e, input logic [7:0] pm_e,
                               input logic halt_e, input logic [1:0] hc_e);
    vec_t v;
    v.rst = 0; v.jmp = 0; v.jnz = 0; v.dz = 0; v.nop = 0; v.req = 0;
    v.res = 0; v.stp = 0; v.bpen = 0; v.nib = 4'h0; v.bpa = 8'h00;
    v.e_pc = pc_e; v.e_pm = pm_e; v.e_halt = halt_e; v.e_hc = hc_e;
    return v;
  endfunction

  // Address the program would go to next, from the architectural rules.
  function automatic logic [7:0] m_nxt(input mdl_t m);
    if (rst) return 8'h00;
    if (jmp || (jnz && !dz)) return {nib, 4'h0};
    return 8'((int'(m.pc) + 1) % 256);
  endfunction

  function automatic logic [7:0] m_pm(input mdl_t m);
    if (m.mode == 1 && !rst) return m.pc;
    return m_nxt(m);
  endfunction

  function automatic mdl_t m_step(input mdl_t m, input bit rh);
    mdl_t r;
    logic [7:0] n;
    r = m;
    n = m_nxt(m);
    if (rst) begin
      r.pc = 8'h00; r.mode = rh ? 1 : 0; r.cause = 2'd0;
      return r;
    end
    r.pc = m_pm(m);
    if (m.mode == 0) begin
      if (nop)                    begin r.mode = 1; r.cause = 2'd1; end
      else if (req)               begin r.mode = 1; r.cause = 2'd2; end
      else if (bpen && n == bpa)  begin r.mode = 1; r.cause = 2'd3; end
    end else if (m.mode == 1) begin
      if (res)      begin r.mode = 0; r.cause = 2'd0; end
      else if (stp) begin r.mode = 2; r.cause = 2'd0; end
    end else begin
      r.mode  = 1;
      r.cause = nop ? 2'd1 : 2'd0;
    end
    return r;
  endfunction

  task automatic chk_model(input string tag, input bit both);
    if (both) begin
      chk({tag, ".pm_addr"},    pm0, m_pm(m0));
      chk({tag, ".pc"},         pc0, m0.pc);
      chk({tag, ".from_PS"},    fps0, m0.pc);
      chk({tag, ".stall"},      8'(st0), 8'(m0.mode == 1));
      chk({tag, ".halt_cause"}, 8'(hc0), 8'(m0.cause));
    end
    chk({tag, ".h.pm_addr"},    pm1, m_pm(m1));
    chk({tag, ".h.pc"},         pc1, m1.pc);
    chk({tag, ".h.halted"},     8'(hl1), 8'(m1.mode == 1));
    chk({tag, ".h.halt_cause"}, 8'(hc1), 8'(m1.cause));
  endtask

  task automatic advance();
    @(posedge clk);
    m0 = m_step(m0, 1'b0);
    m1 = m_step(m1, 1'b1);
    cyc++;
    #1;
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; jmp = v.jmp; jnz = v.jnz; dz = v.dz; nop = v.nop;
    req = v.req; res = v.res; stp = v.stp; bpen = v.bpen; nib = v.nib; bpa = v.bpa;
  endtask

  initial begin
    vec_t v;
    m0 = '{pc: 8'h00, mode: 0, cause: 2'd0};
    m1 = '{pc: 8'h00, mode: 1, cause: 2'd0};

    // ---- vector table ----
    v = row(8'h00, 8'h00, 0, 0); v.rst = 1; tbl.push_back(v);
    for (int i = 0; i < 5; i++) tbl.push_back(row(8'(i), 8'(i + 1), 0, 0));
    v = row(8'h05, 8'h10, 0, 0); v.jmp = 1; v.nib = 4'h1; tbl.push_back(v);
    tbl.push_back(row(8'h10, 8'h11, 0, 0));
    tbl.push_back(row(8'h11, 8'h12, 0, 0));
    v = row(8'h12, 8'hA0, 0, 0); v.jmp = 1; v.nib = 4'hA; tbl.push_back(v);
    v = row(8'hA0, 8'h10, 0, 0); v.jmp = 1; v.nib = 4'h1; tbl.push_back(v);
    tbl.push_back(row(8'h10, 8'h11, 0, 0));
    tbl.push_back(row(8'h11, 8'h12, 0, 0));
    v = row(8'h12, 8'h13, 0, 0); v.jnz = 1; v.dz = 1; v.nib = 4'hA; tbl.push_back(v);
    v = row(8'h13, 8'h30, 0, 0); v.jnz = 1; v.nib = 4'h3; tbl.push_back(v);
    v = row(8'h30, 8'h31, 0, 0); v.nop = 1; tbl.push_back(v);
    v = row(8'h31, 8'h31, 1, 1); v.jmp = 1; v.nib = 4'h5; tbl.push_back(v);
    for (int i = 0; i < 9; i++) tbl.push_back(row(8'h31, 8'h31, 1, 1));
    v = row(8'h31, 8'h31, 1, 1); v.stp = 1; tbl.push_back(v);
    tbl.push_back(row(8'h31, 8'h32, 0, 0));
    v = row(8'h32, 8'h32, 1, 0); v.res = 1; tbl.push_back(v);
    v = row(8'h32, 8'h30, 0, 0); v.jmp = 1; v.nib = 4'h3; v.bpen = 1; v.bpa = 8'h40;
    tbl.push_back(v);
    for (int i = 0; i < 16; i++) begin
      v = row(8'(8'h30 + i), 8'(8'h31 + i), 0, 0); v.bpen = 1; v.bpa = 8'h40;
      tbl.push_back(v);
    end
    v = row(8'h40, 8'h40, 1, 3); v.res = 1; v.bpen = 1; v.bpa = 8'h40; tbl.push_back(v);
    v = row(8'h40, 8'h41, 0, 0); v.bpen = 1; v.bpa = 8'h40; tbl.push_back(v);
    v = row(8'h41, 8'h42, 0, 0); v.bpen = 1; v.bpa = 8'h40; tbl.push_back(v);
    v = row(8'h42, 8'h43, 0, 0); v.req = 1; v.nop = 1; tbl.push_back(v);
    v = row(8'h43, 8'h43, 1, 1); v.res = 1; v.stp = 1; tbl.push_back(v);
    tbl.push_back(row(8'h43, 8'h44, 0, 0));
    v = row(8'h44, 8'h45, 0, 0); v.req = 1; tbl.push_back(v);
    v = row(8'h45, 8'h45, 1, 2); v.stp = 1; tbl.push_back(v);
    v = row(8'h45, 8'h00, 0, 0); v.rst = 1; tbl.push_back(v);
    v = row(8'h00, 8'h00, 0, 0); v.jmp = 1; v.nib = 4'h0; v.req = 1; tbl.push_back(v);
    v = row(8'h00, 8'h00, 1, 2); v.rst = 1; tbl.push_back(v);
    tbl.push_back(row(8'h00, 8'h01, 0, 0));

    // ---- initial reset ----
    apply(row(8'h00, 8'h00, 0, 0));
    rst = 1;
    advance();
    advance();

    // ---- table phase ----
    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(negedge clk);
      chk($sformatf("tbl%0d.pm_addr", i), pm0, tbl[i].e_pm);
      chk($sformatf("tbl%0d.pc", i), pc0, tbl[i].e_pc);
      chk($sformatf("tbl%0d.stall", i), 8'(st0), 8'(tbl[i].e_halt));
      chk($sformatf("tbl%0d.halted", i), 8'(hl0), 8'(tbl[i].e_halt));
      chk($sformatf("tbl%0d.halt_cause", i), 8'(hc0), 8'(tbl[i].e_hc));
      chk_model($sformatf("tbl%0d", i), 1'b0);
      advance();
    end

    // ---- halted-out-of-reset holds address 0 ----
    apply(row(8'h00, 8'h00, 0, 0));
    rst = 1;
    advance();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rh_hold.halted", 8'(hl1), 8'h01);
      chk("rh_hold.stall", 8'(st1), 8'h01);
      chk("rh_hold.pm_addr", pm1, 8'h00);
      chk("rh_hold.pc", pc1, 8'h00);
      chk("run_after_rst.pm_addr", pm0, 8'(i + 1));
      advance();
    end

    // ---- randomized phase ----
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      jmp  = ($urandom_range(0, 7) == 0);
      jnz  = ($urandom_range(0, 5) == 0);
      dz   = 1'($urandom);
      nib  = 4'($urandom);
      nop  = ($urandom_range(0, 19) == 0);
      req  = ($urandom_range(0, 14) == 0);
      res  = ($urandom_range(0, 5) == 0);
      stp  = ($urandom_range(0, 4) == 0);
      bpen = 1'($urandom);
      bpa  = {4'($urandom), 4'($urandom_range(0, 3))};
      @(negedge clk);
      chk_model("rand", 1'b1);
      advance();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Program counter and fetch controller for the 8-bit core, placed between the program memory and `instruction_decoder`. It computes `pm_addr` each cycle from the decoded `jmp`/`jmp_nz` and the ALU zero flag. It also runs a RUN/HALT/STEP debug state machine with a halt instruction (opcode 0xDF), an external halt request, a single-step handshake and one address breakpoint. While halted it holds the fetch address and asserts `stall`, which the top level uses to gate all `reg_en` bits.

## Interface
Parameters:
- `RESET_HALTED`, 0, when 1 the sequencer leaves reset in HALT instead of RUN.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `sync_reset`  in  1  synchronous, active-high reset.
- `jmp`  in  1  unconditional jump decoded from `ir`.
- `jmp_nz`  in  1  conditional jump decoded from `ir`.
- `ir_nibble`  in  4  jump target high nibble.
- `dont_jmp`  in  1  ALU zero flag; when 1, `jmp_nz` is not taken.
- `NOPDF`  in  1  `ir` == 0xDF; this is the halt instruction.
- `dbg_halt_req`  in  1  level-sensitive halt request.
- `dbg_resume`  in  1  one-cycle pulse: leave HALT.
- `dbg_step`  in  1  one-cycle pulse: execute exactly one instruction.
- `dbg_bp_en`  in  1  breakpoint enable.
- `dbg_bp_addr`  in  8  breakpoint address.
- `pm_addr`  out  8  program memory address; combinational.
- `pc`  out  8  registered program counter.
- `from_PS`  out  8  copy of `pc` for the data bus mux.
- `stall`  out  1  when 1, the instruction in `ir` must not commit.
- `halted`  out  1  state == HALT.
- `halt_cause`  out  2  0 none, 1 HALT instruction, 2 `dbg_halt_req`, 3 breakpoint; cleared on leaving HALT.

## Operation
- States: RUN, HALT, STEP. Reset state is RUN, or HALT if `RESET_HALTED`.
- **Next address** (`nxt`), evaluated in priority order:
  - `sync_reset` → 0x00.
  - `jmp` → {`ir_nibble`, 4'h0}.
  - `jmp_nz` & !`dont_jmp` → {`ir_nibble`, 4'h0}.
  - Otherwise `pc`+1, wrapping 0xFF→0x00.
- **`pm_addr`**: equals `pc` in HALT; equals `nxt` in RUN and STEP. Every edge, `pc` <= `pm_addr`.
- **`stall`**: 1 in HALT, 0 in RUN and STEP. `jmp`/`jmp_nz` are ignored while in HALT.
- **RUN→HALT**: taken when any halt cause is present this cycle. The instruction in `ir` still commits and the fetch of `nxt` proceeds, so HALT is entered with `pc` = `nxt`, which has been fetched but not executed.
  - Cause priority for `halt_cause`: instruction (NOPDF) > request (`dbg_halt_req`) > breakpoint (`dbg_bp_en` & `nxt` == `dbg_bp_addr`).
- **HALT→RUN**: on `dbg_resume`. The first RUN cycle executes the instruction at `pc`.
  - The breakpoint compare uses `nxt` only, so resuming at a breakpoint address does not re-trigger.
  - If `dbg_halt_req` is still high, the sequencer re-halts after one instruction.
- **HALT→STEP**: on `dbg_step` with no `dbg_resume`; resume wins when both arrive together.
- **STEP→HALT**: always, after the single instruction. Breakpoints and `dbg_halt_req` are not evaluated in STEP. NOPDF in STEP sets `halt_cause`=1.
- **Reset mid-operation** returns to the reset state from any state: `pc`=0, `pm_addr`=0, `halt_cause`=0.

## Timing
- Reset values:
  - `pc`=0x00, `pm_addr`=0x00, `from_PS`=0x00, `halt_cause`=0.
  - `halted`=`stall`=`RESET_HALTED`.
- `pm_addr` is combinational from `pc`, state and the inputs. `pc` and state are registered. There is no other pipelining.
- Jump latency: the target appears on `pm_addr` in the same cycle `jmp` is high. The target instruction reaches `ir` one edge later.
- Halt latency:
  - `stall` rises one cycle after the cause is sampled.
  - `halted`/`halt_cause` become valid on the same edge.
- Resume/step: `stall` falls one cycle after the pulse. A step gives exactly one cycle with `stall`=0.
- Pulses arriving in RUN (`dbg_resume`, `dbg_step`) are ignored.

## Structure
- Shared package `cpu_pkg`:
  - `seq_state_t` enum {RUN, HALT, STEP}.
  - `halt_cause_t` with constants `HC_NONE`, `HC_INSTR`, `HC_REQ`, `HC_BP`.
  - `OP_HALT`=8'hDF.
- One natural sub-module, `pc_next`: the combinational next-address/jump-resolve logic. The FSM and the registers stay in `program_sequencer`.

## Test plan
- Reset, then 5 cycles in RUN with no jumps → `pm_addr` = 0x01,0x02,0x03,0x04,0x05; `stall`=0.
- `pc`=0x12 with `jmp`=1, `ir_nibble`=0xA → `pm_addr`=0xA0 in that cycle. Repeat with `jmp_nz`=1, `dont_jmp`=1 → `pm_addr`=0x13.
- `pc`=0x30 with NOPDF=1 → next cycle `halted`=1, `halt_cause`=1, `pc`=0x31, held for 10 cycles with `pm_addr`=0x31. Then `dbg_step` → one cycle with `stall`=0, `pc`=0x32, `halted`=1 again.
- `dbg_bp_en`=1, `dbg_bp_addr`=0x40, run from 0x3E → halt with `pc`=0x40, `halt_cause`=3. Then `dbg_resume` → `pm_addr`=0x41 with no re-halt.
- In HALT, `dbg_resume` and `dbg_step` in the same cycle → RUN (resume wins). In RUN, `dbg_halt_req`=1 and NOPDF=1 together → `halt_cause`=1.
- `sync_reset` asserted during STEP and during HALT, with `RESET_HALTED`=0 → next cycle `pc`=0, RUN, `halt_cause`=0. With `RESET_HALTED`=1 → `halted`=1 and `pm_addr`=0 held.
